// File: rtl/max_pool_stage_if.sv
// Sample stream into the pooling stage and pooled stream out of it.
// master drives samples (convolver side), slave is the pooling stage.
interface max_pool_stage_if #(parameter int N = 16);
  logic [N-1:0] data_in;
  logic         valid_in;
  logic [N-1:0] data_out;
  logic         valid_out;
  logic         end_pool;

  modport master (output data_in, valid_in, input data_out, valid_out, end_pool);
  modport slave  (input data_in, valid_in, output data_out, valid_out, end_pool);
endinterface

// File: rtl/max_pool_stage.sv
// Streaming p x p non-overlapping max pooling over an m x m raster feature map,
// with optional ReLU; one line buffer of per-column partial maxima.
module max_pool_stage #(
  parameter int         N    = 16,
  parameter int         Q    = 12,
  parameter logic [8:0] m    = 9'h002,
  parameter int         p    = 2,
  parameter int         RELU = 0
) (
  input logic clk,
  input logic global_rst,
  input logic ce,
  max_pool_stage_if.slave s
);
  localparam int M   = int'(m);
  localparam int PW  = M / p;
  localparam int VL  = PW * p;
  localparam int CLW = $clog2(M + 1);
  localparam int HW  = $clog2(p);
  localparam int PCW = (PW > 1) ? $clog2(PW) : 1;
  localparam int LBD = 1 << PCW;
  localparam logic [CLW-1:0] LAST = CLW'(M - 1);
  localparam logic [CLW-1:0] VLIM = CLW'(VL);
  localparam logic [HW-1:0]  HLST = HW'(p - 1);

  if (p < 2 || Q >= N) begin : g_bad_param
    $error("max_pool_stage: need p >= 2 and Q < N");
  end

  function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [CLW-1:0] col_q, col_d, row_q, row_d;
  logic [HW-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [N-1:0]   hmax_q, hmax_d, dout_q, dout_d;
  logic           vout_q, vout_d, ep_q, ep_d;
  logic [N-1:0]   lb_q [LBD];

  logic           acc, in_reg, col_last, row_last, lb_we;
  logic [N-1:0]   x, w, lb_rd, lb_wd;

  always_comb begin
    acc      = ce & s.valid_in;
    x        = ((RELU != 0) && s.data_in[N-1]) ? '0 : s.data_in;
    in_reg   = (col_q < VLIM) && (row_q < VLIM);
    col_last = (col_q == LAST);
    row_last = (row_q == LAST);
    w        = (hcnt_q == '0) ? x : smax(hmax_q, x);
    lb_rd    = lb_q[pc_q];

    col_d  = col_q;
    row_d  = row_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    pc_d   = pc_q;
    hmax_d = hmax_q;
    dout_d = dout_q;
    vout_d = 1'b0;
    ep_d   = acc && col_last && row_last;
    lb_we  = 1'b0;
    lb_wd  = w;

    if (acc) begin
      col_d = col_last ? '0 : col_q + CLW'(1);
      if (in_reg) begin
        hmax_d = w;
        hcnt_d = (hcnt_q == HLST) ? '0 : hcnt_q + HW'(1);
        pc_d   = (hcnt_q == HLST) ? pc_q + PCW'(1) : pc_q;
        if (hcnt_q == HLST) begin
          // Bottom window row emits; earlier rows fold into the line buffer.
          if (vcnt_q == HLST) begin
            vout_d = 1'b1;
            dout_d = smax(lb_rd, w);
          end else begin
            lb_we = 1'b1;
            lb_wd = (vcnt_q == '0) ? w : smax(lb_rd, w);
          end
        end
      end
      if (col_last) begin
        hcnt_d = '0;
        pc_d   = '0;
        row_d  = row_last ? '0 : row_q + CLW'(1);
        vcnt_d = (row_last || vcnt_q == HLST) ? '0 : vcnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      col_q  <= '0;
      row_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      pc_q   <= '0;
      hmax_q <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      ep_q   <= 1'b0;
      for (int i = 0; i < LBD; i++) lb_q[i] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      pc_q   <= pc_d;
      hmax_q <= hmax_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      ep_q   <= ep_d;
      if (lb_we) lb_q[pc_q] <= lb_wd;
    end
  end

  assign s.data_out  = dout_q;
  assign s.valid_out = vout_q;
  assign s.end_pool  = ep_q;
endmodule

// File: doc/max_pool_stage.md
Name: max_pool_stage

Overview:
Streaming fixed-point max-pooling stage placed directly downstream of the convolver. It consumes the convolver's valid-qualified output samples (conv_op / valid_conv) in raster order over an m x m feature map. It applies an optional ReLU, then emits one maximum per non-overlapping p x p window. A single line buffer holds per-column partial maxima, so no full frame storage is needed.

Parameters:
N, 16, sample width in bits (two's-complement fixed point)
Q, 12, fractional bits (carried through unchanged; compare is format-agnostic)
m, 9'h002, feature-map side length in valid samples (= n-k+1 of the convolver)
p, 2, pool window side and pool stride (p >= 2)
RELU, 0, 1 = clamp negative inputs to 0 before pooling

Ports:
clk  input  1  system clock
global_rst  input  1  synchronous active-high reset
ce  input  1  clock enable; when 0, all internal state holds
data_in  input  N  input sample (convolver conv_op)
valid_in  input  1  data_in is a feature-map sample (convolver valid_conv)
data_out  output  N  pooled maximum
valid_out  output  1  one-cycle pulse: data_out holds a new pooled value
end_pool  output  1  one-cycle pulse: the last sample of the frame has been consumed

Behaviour:
- Reset: one clock, synchronous, active-high. Only global_rst on a rising clk edge resets. On reset: data_out=0, valid_out=0, end_pool=0, all counters 0, running max cleared, line-buffer valid bits cleared. Reset takes priority over ce. Reset mid-frame discards the partial frame; the next accepted sample is treated as (row 0, col 0).
- Accept: a sample is accepted when ce=1, valid_in=1 and global_rst=0. Cycles with ce=0 or valid_in=0 change no counter, max or buffer state. Gaps of any length between samples are legal.
- Counters: col in 0..m-1 and row in 0..m-1 advance only on accept. col wraps to 0 at m-1 and increments row. row wraps to 0 at m-1, so the next accept starts a new frame with no idle cycle required.
- ReLU: when RELU=1, x = (data_in sign bit set) ? 0 : data_in. Otherwise x = data_in.
- Compare: all max operations are signed N-bit comparisons. No width growth and no rounding.
- Valid region: only samples with col < (m/p)*p and row < (m/p)*p participate. Trailing columns and rows (m not divisible by p) are consumed but discarded. Output grid is (m/p) x (m/p).
- Horizontal pass: running register hmax.
  - col%p==0: load hmax=x.
  - Otherwise: hmax=max(hmax,x).
- At col%p==p-1 (window row complete), with w = max(hmax,x) and pc = col/p:
  - row%p==0: linebuf[pc] = w.
  - 0 < row%p < p-1: linebuf[pc] = max(linebuf[pc], w).
  - row%p==p-1: data_out <= max(linebuf[pc], w) and valid_out <= 1.
- Latency: valid_out/data_out are registered and appear in the cycle after the accept of the window's bottom-right sample (1-cycle latency). data_out holds its value until the next pooled result.
- valid_out is 0 in every cycle that does not follow such an accept, including ce=0 cycles.
- end_pool: pulses 1 in the cycle after the accept of sample (row m-1, col m-1), irrespective of whether that sample was in the valid region. When m%p==0 it coincides with the last valid_out.
- Line buffer: m/p entries of N bits, indexed by pc. A single read and a single write of the same entry occur per window-row completion, so there is no read/write hazard.
- No back-pressure: downstream must accept each valid_out pulse. Maximum throughput is one sample per cycle.

Test Plan:
- m=4, p=2, RELU=0, inputs 0..15 raster, valid_in held 1 -> valid_out pulses carrying 5, 7, 13, 15, each in the cycle after inputs 5, 7, 13, 15. end_pool pulses together with the 15 output.
- Same frame with valid_in low on random cycles and ce=0 for 3 cycles mid-row -> identical outputs 5, 7, 13, 15 in order. No valid_out pulse while ce=0.
- m=4, p=2, all inputs 16'hFFF8 (-8) -> RELU=0: four outputs 16'hFFF8. RELU=1: four outputs 16'h0000.
- m=5, p=2, inputs 0..24 -> outputs 6, 8, 16, 18 only. Samples from col 4 and row 4 produce no output. end_pool pulses the cycle after input 24.
- m=4, global_rst asserted after 6 accepted samples, then fresh frame 0..15 -> outputs exactly 5, 7, 13, 15. All outputs are 0 in the cycle after reset.
- Two back-to-back frames, inputs 0..15 then 15..0 -> outputs 5, 7, 13, 15 then 15, 13, 7, 5. end_pool pulses twice, with no idle cycle between frames.
